operand_bank_loader: RTL and testbench



---
 rtl/operand_bank_loader_pkg.sv | 31 +++
 rtl/operand_bank_loader_tag_delay_line.sv | 27 ++
 rtl/operand_bank_loader.sv | 127 ++++++++++++
 tb/tb_operand_bank_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_bank_loader_pkg.sv
// rtl/operand_bank_loader_pkg.sv - shared geometry and tag layout for the operand bank loader
// Widths here must track the matrix-multiplier controller's count/select definitions.
package operand_bank_loader_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int BANKS        = 8;
  localparam int DEPTH        = 8;
  localparam int RD_LATENCY   = 2;

  localparam int BANK_IDX_W   = $clog2(BANKS);
  localparam int SEL_W        = $clog2(DEPTH);
  localparam int BANK_W       = BANK_IDX_W + 1;
  localparam int BANK_OOR_BIT = BANK_IDX_W;
  localparam int TAG_W        = 1 + BANK_W + SEL_W;
  localparam int ENTRIES      = BANKS * DEPTH;
  localparam int ENTRY_W      = $clog2(ENTRIES);
  localparam int COUNT_W      = $clog2(ENTRIES + 1);
  localparam int VEC_W        = BANKS * DATA_WIDTH;

  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
    logic [SEL_W-1:0]  sel;
  } tag_t;

  // Flat mask index; only meaningful when the out-of-range bit is clear.
  function automatic logic [ENTRY_W-1:0] entry_index(input tag_t t);
    return {t.bank[BANK_IDX_W-1:0], t.sel};
  endfunction

endpackage

// File: rtl/operand_bank_loader_tag_delay_line.sv
// rtl/operand_bank_loader_tag_delay_line.sv - enable-gated shift register aligning tags to read data
// STAGES must be at least 1; every stage holds while en_i is low.
module tag_delay_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/operand_bank_loader.sv
// rtl/operand_bank_loader.sv - captures ROM/RAM read data into A/B banks and feeds column slices
// load_done is the LOADING->READY flag; clear is the only way back to LOADING.
module operand_bank_loader
  import operand_bank_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [BANK_W-1:0]     bank_select_line,
  input  logic [SEL_W-1:0]      select_line,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic [DATA_WIDTH-1:0] ram_data,
  input  logic                  clear,
  input  logic                  feed_en,
  input  logic [SEL_W-1:0]      feed_index,
  output logic [VEC_W-1:0]      a_vec,
  output logic [VEC_W-1:0]      b_vec,
  output logic                  feed_valid,
  output logic                  feed_err,
  output logic                  load_done,
  output logic [COUNT_W-1:0]    entry_count
);

  tag_t tag_in, tag_out;

  assign tag_in = {read_en, bank_select_line, select_line};

  tag_delay_line #(
    .WIDTH  (TAG_W),
    .STAGES (RD_LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (enable),
    .d_i   (tag_in),
    .q_o   (tag_out)
  );

  // Clear outranks a landing write: neither the data nor the mask bit is taken.
  logic                  write_hit;
  logic [ENTRY_W-1:0]    wr_idx;
  logic [BANK_IDX_W-1:0] wr_bank;

  assign write_hit = enable & tag_out.valid & ~tag_out.bank[BANK_OOR_BIT] & ~clear;
  assign wr_idx    = entry_index(tag_out);
  assign wr_bank   = tag_out.bank[BANK_IDX_W-1:0];

  logic [DATA_WIDTH-1:0] a_mem_q [BANKS][DEPTH];
  logic [DATA_WIDTH-1:0] b_mem_q [BANKS][DEPTH];

  always_ff @(posedge clk) begin
    if (write_hit) begin
      a_mem_q[wr_bank][tag_out.sel] <= rom_data;
      b_mem_q[wr_bank][tag_out.sel] <= ram_data;
    end
  end

  logic [ENTRIES-1:0] mask_q, mask_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;

  // Counting only first writes keeps the count equal to the mask popcount.
  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    if (clear) begin
      mask_d  = '0;
      count_d = '0;
    end else if (write_hit && !mask_q[wr_idx]) begin
      mask_d[wr_idx] = 1'b1;
      count_d        = count_q + COUNT_W'(1);
    end
    done_d = (count_d == COUNT_W'(ENTRIES));
  end

  logic             feed_hit, feed_miss;
  logic [VEC_W-1:0] a_col, b_col;

  assign feed_hit  = enable & feed_en & done_q;
  assign feed_miss = enable & feed_en & ~done_q;

  always_comb begin
    a_col = '0;
    b_col = '0;
    for (int i = 0; i < BANKS; i++) begin
      a_col[i*DATA_WIDTH +: DATA_WIDTH] = a_mem_q[i][feed_index];
      b_col[i*DATA_WIDTH +: DATA_WIDTH] = b_mem_q[i][feed_index];
    end
  end

  logic [VEC_W-1:0] a_vec_q, b_vec_q;
  logic             feed_valid_q, feed_err_q;

  // Pulses are rebuilt every cycle so a stall forces them low instead of stretching them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      a_vec_q      <= '0;
      b_vec_q      <= '0;
      feed_valid_q <= 1'b0;
      feed_err_q   <= 1'b0;
    end else begin
      feed_valid_q <= feed_hit;
      feed_err_q   <= feed_miss;
      if (enable) begin
        mask_q  <= mask_d;
        count_q <= count_d;
        done_q  <= done_d;
        if (feed_hit) begin
          a_vec_q <= a_col;
          b_vec_q <= b_col;
        end
      end
    end
  end

  assign a_vec       = a_vec_q;
  assign b_vec       = b_vec_q;
  assign feed_valid  = feed_valid_q;
  assign feed_err    = feed_err_q;
  assign load_done   = done_q;
  assign entry_count = count_q;

endmodule

// File: tb/tb_operand_bank_loader.sv
// tb/tb_operand_bank_loader.sv - scoreboard bench for operand_bank_loader
module tb_operand_bank_loader;
  import operand_bank_loader_pkg::*;

  logic              clk, reset, enable, read_en, clear, feed_en;
  logic [3:0]        bank_select_line;
  logic [2:0]        select_line, feed_index;
  logic [31:0]       rom_data, ram_data;
  logic [VEC_W-1:0]  a_vec, b_vec;
  logic              feed_valid, feed_err, load_done;
  logic [6:0]        entry_count;

  operand_bank_loader dut (
    .clk(clk), .reset(reset), .enable(enable), .read_en(read_en),
    .bank_select_line(bank_select_line), .select_line(select_line),
    .rom_data(rom_data), .ram_data(ram_data), .clear(clear),
    .feed_en(feed_en), .feed_index(feed_index), .a_vec(a_vec), .b_vec(b_vec),
    .feed_valid(feed_valid), .feed_err(feed_err), .load_done(load_done),
    .entry_count(entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic             valid;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
  } exp_t;
  exp_t sb_q[$];

  // Reference state: bank contents, written mask, last fed vectors, and a 2-deep read pipeline.
  logic [31:0]      ma [8][8];
  logic [31:0]      mb [8][8];
  logic [63:0]      mmask;
  int               mcount;
  logic             mdone;
  logic [VEC_W-1:0] m_av, m_bv;
  logic             pv  [2];
  logic [3:0]       pbk [2];
  logic [2:0]       psl [2];
  logic [31:0]      prd [2];
  logic [31:0]      pwd [2];

  task automatic model_reset();
    mmask = '0; mcount = 0; mdone = 1'b0; m_av = '0; m_bv = '0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pbk[i] = '0; psl[i] = '0; prd[i] = '0; pwd[i] = '0;
    end
  endtask

  // One clock cycle of stimulus; returns just after the edge that consumes it.
  task automatic cyc(input logic en, input logic re, input logic [3:0] bk, input logic [2:0] sl,
                     input logic [31:0] rd, input logic [31:0] wd, input logic clr,
                     input logic fe, input logic [2:0] fi);
    exp_t e;
    int   idx;
    enable = en; read_en = re; bank_select_line = bk; select_line = sl;
    clear = clr; feed_en = fe; feed_index = fi;
    if (en) begin rom_data = prd[1]; ram_data = pwd[1]; end
    else begin rom_data = $urandom; ram_data = $urandom; end
    if (en) begin
      if (fe) begin
        e.valid = mdone;
        if (mdone) begin
          for (int i = 0; i < 8; i++) begin
            m_av[i*32 +: 32] = ma[i][fi];
            m_bv[i*32 +: 32] = mb[i][fi];
          end
        end
        e.a = m_av; e.b = m_bv;
        sb_q.push_back(e);
      end
      if (clr) begin
        mmask = '0; mcount = 0;
      end else if (pv[1] && !pbk[1][3]) begin
        idx = int'(pbk[1][2:0]) * 8 + int'(psl[1]);
        ma[pbk[1][2:0]][psl[1]] = prd[1];
        mb[pbk[1][2:0]][psl[1]] = pwd[1];
        if (!mmask[idx]) begin mmask[idx] = 1'b1; mcount++; end
      end
      mdone = (mcount == 64);
      pv[1] = pv[0]; pbk[1] = pbk[0]; psl[1] = psl[0]; prd[1] = prd[0]; pwd[1] = pwd[0];
      pv[0] = re; pbk[0] = bk; psl[0] = sl; prd[0] = rd; pwd[0] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 4'd0, 3'd0, 32'd0, 32'd0, 0, 0, 3'd0);
  endtask

  task automatic wr(input int b, input int s, input logic [31:0] rd, input logic [31:0] wd);
    cyc(1, 1, 4'(b), 3'(s), rd, wd, 0, 0, 3'd0);
  endtask

  task automatic feed(input int fi);
    cyc(1, 0, 4'd0, 3'd0, 32'd0, 32'd0, 0, 1, 3'(fi));
  endtask

  task automatic std_wr(input int b, input int s);
    wr(b, s, 32'(32'h1000 + b*8 + s), 32'(32'h2000 + b*8 + s));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (feed_valid || feed_err)) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got valid=%b err=%b, expected no pulse", feed_valid, feed_err);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind", {feed_valid, feed_err}, {e.valid, ~e.valid});
        chk("sb_a_vec", a_vec, e.a);
        chk("sb_b_vec", b_vec, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    reset = 1'b1; enable = 1'b1; read_en = 0; clear = 0; feed_en = 0;
    bank_select_line = '0; select_line = '0; feed_index = '0; rom_data = '0; ram_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_vec", a_vec, '0);
    chk("rst_b_vec", b_vec, '0);
    chk("rst_count", entry_count, 0);
    chk("rst_done", load_done, 0);
    chk("rst_pulses", {feed_valid, feed_err}, 0);
    reset = 1'b0;

    // Partial load of 10 entries, then a feed before load_done.
    for (int i = 0; i < 10; i++) std_wr(i / 8, i % 8);
    idle(2);
    chk("partial_count", entry_count, 10);
    feed(0);
    chk("early_err", feed_err, 1);
    chk("early_valid", feed_valid, 0);
    chk("early_a_hold", a_vec, '0);
    idle(1);
    chk("early_err_pulse", feed_err, 0);

    // Overwrite A[2][5]: second write updates data without counting again.
    wr(2, 5, 32'hAA, 32'h55);
    wr(2, 5, 32'hBB, 32'h66);
    idle(2);
    chk("overwrite_count", entry_count, 11);

    for (int b = 0; b < 8; b++)
      for (int s = 0; s < 8; s++)
        if (!(b == 2 && s == 5)) std_wr(b, s);
    idle(1);
    chk("pre_last_count", entry_count, 63);
    chk("pre_last_done", load_done, 0);
    idle(1);
    chk("full_count", entry_count, 64);
    chk("full_done", load_done, 1);

    feed(3);
    chk("feed3_valid", feed_valid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("feed3_a_lane", a_vec[i*32 +: 32], 32'(32'h1000 + i*8 + 3));
      chk("feed3_b_lane", b_vec[i*32 +: 32], 32'(32'h2000 + i*8 + 3));
    end
    idle(1);
    chk("feed3_pulse", feed_valid, 0);
    feed(5);
    chk("overwrite_a", a_vec[2*32 +: 32], 32'hBB);
    chk("overwrite_b", b_vec[2*32 +: 32], 32'h66);

    // Out-of-range bank 8 must not alias onto bank 0.
    wr(8, 0, 32'hDEAD, 32'hBEEF);
    idle(2);
    chk("oor_count", entry_count, 64);
    feed(0);
    chk("oor_a_lane0", a_vec[31:0], 32'h1000);
    chk("oor_b_lane0", b_vec[31:0], 32'h2000);

    // Feed in the landing cycle of a write sees the old data.
    wr(0, 1, 32'h77, 32'h88);
    idle(1);
    feed(1);
    chk("rbw_old", a_vec[31:0], 32'h1001);
    feed(1);
    chk("rbw_new", a_vec[31:0], 32'h77);
    chk("rbw_new_b", b_vec[31:0], 32'h88);

    // Clear coincident with a landing write and a feed.
    wr(1, 1, 32'h99, 32'h99);
    idle(1);
    cyc(1, 0, 4'd0, 3'd0, 32'd0, 32'd0, 1, 1, 3'd1);
    chk("clear_count", entry_count, 0);
    chk("clear_done", load_done, 0);
    chk("clear_feed_valid", feed_valid, 1);
    chk("clear_feed_lane1", a_vec[63:32], 32'h1009);
    feed(1);
    chk("post_clear_err", feed_err, 1);

    // Async reset at 40 entries with tags in flight and a feed pending.
    for (int i = 0; i < 40; i++) std_wr(i / 8, i % 8);
    idle(2);
    chk("count40", entry_count, 40);
    wr(5, 0, 32'h5, 32'h5);
    wr(5, 1, 32'h6, 32'h6);
    feed_en = 1'b1; feed_index = 3'd0;
    #1 reset = 1'b1;
    #1;
    chk("areset_a_vec", a_vec, '0);
    chk("areset_b_vec", b_vec, '0);
    chk("areset_count", entry_count, 0);
    chk("areset_done", load_done, 0);
    chk("areset_pulses", {feed_valid, feed_err}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    feed_en = 1'b0;
    reset = 1'b0;
    idle(3);
    chk("inflight_dropped", entry_count, 0);

    // Full reload with a 5-cycle stall after 20 tags.
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        repeat (5) cyc(0, 1, 4'($urandom_range(15)), 3'($urandom_range(7)),
                       32'($urandom), 32'($urandom), 0, 0, 3'd0);
        chk("stall_count", entry_count, 18);
      end
      std_wr(i / 8, i % 8);
    end
    idle(1);
    chk("reload_pre_done", load_done, 0);
    chk("reload_pre_count", entry_count, 63);
    idle(1);
    chk("reload_done", load_done, 1);
    chk("reload_count", entry_count, 64);
    for (int j = 0; j < 8; j++) begin
      feed(j);
      for (int i = 0; i < 8; i++) begin
        chk("reload_a_lane", a_vec[i*32 +: 32], 32'(32'h1000 + i*8 + j));
        chk("reload_b_lane", b_vec[i*32 +: 32], 32'(32'h2000 + i*8 + j));
      end
    end
    idle(2);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
